// File: rtl/test_pattern_gen.sv
// Multi-channel test-pattern source: up/down count, walking one or Galois LFSR base,
// fanned out to CHANNELS lanes at a programmable rate with a valid/ready output.
module test_pattern_gen #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CHANNELS  = 4,
  parameter int unsigned      DIV_W     = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                      ref_clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          seed,
  input  logic [DIV_W-1:0]          div,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      wrap,
  output logic                      overrun
);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {M_UP = 2'd0, M_DOWN = 2'd1, M_WALK = 2'd2, M_LFSR = 2'd3} mode_t;

  state_t                    r_state, w_state_next;
  mode_t                     r_mode;
  logic [WIDTH-1:0]          r_base, r_seed;
  logic [WIDTH-1:0]          w_base_next, w_seed_eff;
  logic [DIV_W-1:0]          r_presc;
  logic                      w_tick, w_slot_free, w_accept, w_wrap_cond;
  logic [CHANNELS*WIDTH-1:0] w_lanes;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned s);
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v} << s;
    return dbl[2*WIDTH-1 -: WIDTH];
  endfunction

  always_comb begin
    w_state_next = en ? S_RUN : S_IDLE;
  end

  assign w_tick      = (r_state == S_RUN) && (r_presc == div);
  assign w_slot_free = !out_valid || out_ready;
  assign w_accept    = out_valid && out_ready;

  // A zero seed would lock walking-one and LFSR modes at zero forever.
  assign w_seed_eff = (mode[1] && (seed == '0)) ? WIDTH'(1) : seed;

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    w_base_next = r_base;
    w_wrap_cond = 1'b0;
    case (r_mode)
      M_UP: begin
        w_base_next = r_base + WIDTH'(1);
        w_wrap_cond = &r_base;
      end
      M_DOWN: begin
        w_base_next = r_base - WIDTH'(1);
        w_wrap_cond = (r_base == '0);
      end
      M_WALK: begin
        w_base_next = {r_base[WIDTH-2:0], r_base[WIDTH-1]};
        w_wrap_cond = r_base[WIDTH-1];
      end
      M_LFSR: begin
        w_base_next = (r_base >> 1) ^ (r_base[0] ? LFSR_TAPS : '0);
        w_wrap_cond = (w_base_next == r_seed);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_lanes = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      case (r_mode)
        M_UP:    w_lanes[c*WIDTH +: WIDTH] = r_base + WIDTH'(c);
        M_DOWN:  w_lanes[c*WIDTH +: WIDTH] = r_base - WIDTH'(c);
        default: w_lanes[c*WIDTH +: WIDTH] = rotl(r_base, int'(unsigned'(c) % WIDTH));
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= M_UP;
      r_base    <= WIDTH'(1);
      r_seed    <= WIDTH'(1);
      r_presc   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      wrap    <= 1'b0;
      if (load) begin
        r_mode    <= mode_t'(mode);
        r_seed    <= w_seed_eff;
        r_base    <= w_seed_eff;
        r_presc   <= '0;
        out_valid <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        if (r_state == S_RUN) begin
          r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
        end else begin
          r_presc <= '0;
        end

        if (w_tick) begin
          if (w_slot_free) begin
            out_data  <= w_lanes;
            out_valid <= 1'b1;
            r_base    <= w_base_next;
            wrap      <= w_wrap_cond;
          end else begin
            overrun <= 1'b1;
          end
        end else if (w_accept) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: a high-level sequence model fills the expected
// queue on every load; a negedge monitor pops and compares each accepted sample.
module tb_test_pattern_gen;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int DIV_W    = 16;
  localparam int DW       = CHANNELS * WIDTH;
  localparam logic [7:0] TAPS = 8'hB8;

  logic             ref_clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;
  logic [DIV_W-1:0] div;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             wrap;
  logic             overrun;

  test_pattern_gen #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV_W(DIV_W), .LFSR_TAPS(TAPS)
  ) dut (
    .ref_clk  (ref_clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .mode     (mode),
    .seed     (seed),
    .div      (div),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wrap     (wrap),
    .overrun  (overrun)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            wrap;
  } exp_t;

  exp_t          sb_q[$];
  bit            wflags[$];
  logic [DW-1:0] acc_q[$];
  longint        acc_t[$];
  int            wrap_seen;
  longint        cyc;
  int            n_checks;
  int            n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < s % 8; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 8'h00);
  endfunction

  function automatic logic [DW-1:0] lanes_of(input logic [1:0] m, input logic [7:0] b);
    logic [DW-1:0] r;
    logic [7:0]    l;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (m)
        2'd0:    l = b + 8'(c);
        2'd1:    l = b - 8'(c);
        default: l = rotl8(b, c);
      endcase
      r[c*8 +: 8] = l;
    end
    return r;
  endfunction

  // Expected sample sequence after a (re)start: base k is a closed form of the seed,
  // except the LFSR which is simply iterated.
  task automatic sb_load(input logic [1:0] m, input logic [7:0] s, input int n);
    logic [7:0] seff, b, b3;
    exp_t       e;
    sb_q.delete();
    wflags.delete();
    acc_q.delete();
    acc_t.delete();
    wrap_seen = 0;
    seff = (m >= 2 && s == 8'h00) ? 8'h01 : s;
    b3 = seff;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'd0:    b = seff + 8'(k);
        2'd1:    b = seff - 8'(k);
        2'd2:    b = rotl8(seff, k);
        default: b = b3;
      endcase
      e.data = lanes_of(m, b);
      case (m)
        2'd0:    e.wrap = (b == 8'hFF);
        2'd1:    e.wrap = (b == 8'h00);
        2'd2:    e.wrap = b[7];
        default: e.wrap = (lfsr_step(b) == seff);
      endcase
      b3 = lfsr_step(b3);
      sb_q.push_back(e);
      wflags.push_back(e.wrap);
    end
  endtask

  function automatic int exp_wraps(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n && i < wflags.size(); i++) s += int'(wflags[i]);
    return s;
  endfunction

  always @(posedge ref_clk) cyc++;

  // Monitor: a load in the same cycle voids any handshake, so such cycles are skipped.
  always @(negedge ref_clk) begin
    if (rst_n && !load) begin
      if (wrap) begin
        wrap_seen++;
        check("wrap_align", {62'd0, out_valid, (sb_q.size() > 0) ? sb_q[0].wrap : 1'b0}, 64'd3);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          fail_now("sb_empty");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sample", 64'(out_data), 64'(e.data));
          acc_q.push_back(out_data);
          acc_t.push_back(cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] m, input logic [7:0] s, input logic [15:0] d, input int n);
    mode = m;
    seed = s;
    div  = d;
    load = 1'b1;
    sb_load(m, s, n);
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    while (!out_valid && edges < budget) begin
      step(1);
      edges++;
    end
    if (!out_valid) fail_now("wait_valid");
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k;
    k = 0;
    while (acc_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (acc_q.size() < n) fail_now("wait_acc");
  endtask

  task automatic drain();
    out_ready = 1'b1;
    en = 1'b0;
    step(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_checks = 0; n_fail = 0; cyc = 0; wrap_seen = 0;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; out_ready = 1'b0;
    mode = 2'd0; seed = 8'h00; div = '0;
    sb_load(2'd0, 8'h01, 16);

    #12;
    check("rst_valid",   64'(out_valid), 64'd0);
    check("rst_data",    64'(out_data),  64'd0);
    check("rst_wrap",    64'(wrap),      64'd0);
    check("rst_overrun", 64'(overrun),   64'd0);
    @(posedge ref_clk); #1;
    rst_n = 1'b1;
    step(3);
    check("idle_no_valid", 64'(out_valid), 64'd0);

    // Up count from FE, full rate.
    out_ready = 1'b1;
    en = 1'b1;
    do_load(2'd0, 8'hFE, 16'd0, 64);
    wait_valid(10, lat);
    check("lat_div0", 64'(lat), 64'd1);
    wait_acc(10, 40);
    drain();
    check("up_s0", 64'(acc_q[0]), 64'h0100FFFE);
    check("up_s1", 64'(acc_q[1]), 64'h020100FF);
    check("up_rate", 64'(acc_t[2] - acc_t[1]), 64'd1);
    check("up_wraps", 64'(wrap_seen), 64'(exp_wraps(acc_q.size())));
    check("up_wraps_once", 64'(wrap_seen), 64'd1);
    check("up_no_overrun", 64'(overrun), 64'd0);

    // Down count from 0, one sample per 4 cycles.
    en = 1'b1;
    do_load(2'd1, 8'h00, 16'd3, 64);
    wait_valid(20, lat);
    check("lat_div3", 64'(lat), 64'd4);
    wait_acc(4, 40);
    drain();
    check("dn_s0", 64'(acc_q[0]), 64'hFDFEFF00);
    check("dn_s1", 64'(acc_q[1]), 64'hFCFDFEFF);
    check("dn_rate", 64'(acc_t[1] - acc_t[0]), 64'd4);
    check("dn_wraps", 64'(wrap_seen), 64'(exp_wraps(acc_q.size())));

    // Walking one with zero seed forced to 01.
    en = 1'b1;
    do_load(2'd2, 8'h00, 16'd0, 64);
    wait_acc(10, 40);
    drain();
    check("walk_s0", 64'(acc_q[0]), 64'h08040201);
    check("walk_s8", 64'(acc_q[8]), 64'h08040201);
    check("walk_wraps", 64'(wrap_seen), 64'(exp_wraps(acc_q.size())));

    // LFSR from 01: period 255.
    en = 1'b1;
    do_load(2'd3, 8'h01, 16'd0, 300);
    wait_acc(258, 400);
    drain();
    check("lfsr_b1",   64'(acc_q[1][7:0]),   64'hB8);
    check("lfsr_b2",   64'(acc_q[2][7:0]),   64'h5C);
    check("lfsr_b255", 64'(acc_q[255][7:0]), 64'h01);
    check("lfsr_wraps", 64'(wrap_seen), 64'd1);

    // Backpressure: samples dropped, base held, sequence resumes without a gap.
    en = 1'b1;
    do_load(2'd0, 8'h10, 16'd0, 64);
    wait_acc(3, 20);
    out_ready = 1'b0;
    step(6);
    check("bp_valid",   64'(out_valid), 64'd1);
    check("bp_frozen",  64'(out_data),  64'((sb_q.size() > 0) ? sb_q[0].data : '0));
    check("bp_overrun", 64'(overrun),   64'd1);
    out_ready = 1'b1;
    wait_acc(10, 40);
    check("bp_sticky", 64'(overrun), 64'd1);

    // Load while a sample is pending, then async reset mid-count.
    out_ready = 1'b0;
    step(3);
    check("pre_load_valid", 64'(out_valid), 64'd1);
    do_load(2'd0, 8'h40, 16'd3, 64);
    check("load_valid_clr",   64'(out_valid), 64'd0);
    check("load_overrun_clr", 64'(overrun),   64'd0);
    out_ready = 1'b1;
    wait_valid(20, lat);
    check("load_lat", 64'(lat), 64'd4);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",   64'(out_valid), 64'd0);
    check("arst_data",    64'(out_data),  64'd0);
    check("arst_wrap",    64'(wrap),      64'd0);
    check("arst_overrun", 64'(overrun),   64'd0);
    en = 1'b0;
    div = '0;
    sb_load(2'd0, 8'h01, 64);
    @(posedge ref_clk); #1;
    rst_n = 1'b1;
    step(3);
    check("post_rst_no_valid", 64'(out_valid), 64'd0);
    en = 1'b1;
    wait_acc(2, 20);
    drain();
    check("post_rst_base1", 64'(acc_q[0]), 64'h04030201);

    // Randomised runs: random mode/seed/rate, random backpressure and enable gaps.
    for (int it = 0; it < 8; it++) begin
      en = 1'b1;
      out_ready = 1'b1;
      do_load(2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom_range(0, 2)), 400);
      for (int k = 0; k < 150; k++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        en = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0 && div < 16'd3) div = div + 16'd1;
        step(1);
      end
      drain();
      check("rand_progress", 64'(acc_q.size() > 0), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
Name: test_pattern_gen

Overview:
Parametrised multi-channel test-pattern source that replaces the fixed free-running counter on the top-level output.
- Produces CHANNELS lanes of WIDTH bits at a programmable rate derived from ref_clk.
- Four pattern modes; valid/ready output handshake; sticky overrun flag; wrap pulse.
- Sits between the clocking logic and any consumer: output pins, ILA, or downstream checker.

Parameters:
WIDTH, 8, bits per channel (≥2)
CHANNELS, 4, number of output lanes (≥1)
DIV_W, 16, width of rate divider
LFSR_TAPS, 8'hB8, Galois LFSR feedback mask (WIDTH bits)

Ports:
ref_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable
load  in  1  single-cycle pulse: latch mode/seed, restart
mode  in  2  0=up count, 1=down count, 2=walking one, 3=LFSR; sampled only on load
seed  in  WIDTH  initial base value; sampled only on load
div  in  DIV_W  sample period = div+1 ref_clk cycles; read live
out_data  out  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH]
out_valid  out  1  out_data holds an unconsumed sample
out_ready  in  1  consumer accepts when out_valid && out_ready
wrap  out  1  one-cycle pulse when the base pattern completes a cycle
overrun  out  1  sticky: a sample was dropped because output was full

Behaviour:
- Reset (async assert, sync release): state=IDLE, base=1, mode_r=0, seed_r=1, presc=0, out_data=0, out_valid=0, wrap=0, overrun=0.
- FSM IDLE/RUN:
  - IDLE→RUN when en=1; RUN→IDLE when en=0.
  - presc cleared on every IDLE cycle; out_valid/out_data untouched in IDLE.
- Prescaler (RUN only): tick when presc==div, then presc<=0; else presc+1.
  - div=0 ticks every cycle.
  - div changed mid-count: compare uses the new value.
  - If presc > new div, count on to 2^DIV_W-1, wrap to 0, continue.
- On tick:
  - If !out_valid or out_ready (slot free this cycle): out_data<=lanes(base), out_valid<=1 next cycle, base advances.
  - Otherwise: sample dropped, base held, overrun<=1.
- Accept without tick: out_valid<=0.
- Lane function, c = 0..CHANNELS-1, all arithmetic mod 2^WIDTH:
  - mode 0: base+c
  - mode 1: base−c
  - mode 2/3: base rotated left by (c mod WIDTH)
- Base advance:
  - mode 0: +1; wrap when base goes all-ones→0.
  - mode 1: −1; wrap when 0→all-ones.
  - mode 2: rotate left 1; wrap when MSB moves to bit0.
  - mode 3: Galois step, base = (base>>1) ^ (base[0] ? LFSR_TAPS : 0); wrap when next base == seed_r.
  - wrap asserted the cycle after the advancing tick.
- load (highest priority, any state):
  - mode_r<=mode; seed_r<=seed; base<=seed.
  - Modes 2/3 with seed==0 force base=seed_r=1. Mode 2 does not normalise non-one-hot seeds.
  - presc<=0; out_valid<=0 (pending sample discarded); overrun<=0; wrap<=0.
  - Any tick or handshake in the same cycle is ignored.
- Latency: load+en at cycle 0 → first tick at RUN cycle div → out_valid high one cycle later, with lanes(seed).
- Reset asserted mid-operation: all state returns to reset values immediately; no sample emitted after release until a tick.

Test Plan:
- WIDTH=8, CHANNELS=4, mode 0, seed=8'hFE, div=0, en=1, out_ready=1 → consecutive samples {FE,FF,00,01}, then {FF,00,01,02}; wrap pulses once, after the FF→00 advance.
- mode 1, seed=0, div=3 → one sample per 4 cycles: {00,FF,FE,FD}, then {FF,FE,FD,FC}; wrap after the first advance.
- mode 2, seed=0 → forced seed 01; lanes {01,02,04,08}; wrap on the 8th advance; base returns to 01.
- mode 3, seed=8'h01, LFSR_TAPS=B8 → base sequence 01,B8,5C,…; wrap pulses when base returns to 01 after 255 ticks.
- out_ready=0 with div=0 for 5 cycles → out_valid stays high, out_data frozen, overrun=1, base held. Raise out_ready → next sample is the held-base successor; no gap in the sequence.
- Pulse load mid-run while out_valid=1, then toggle rst_n low mid-count → out_valid and overrun clear on load, presc restarts at 0; after rst_n low all outputs are 0 and base=1.
